// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : stall/flush sequencer for the 5-stage MIPS pipeline
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_ins,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  localparam logic [1:0]  c_ls_init = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] c_to_last = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_eff_state;
  logic [1:0]       r_ls_cnt;
  logic [1:0]       w_ls_cnt_nxt;
  logic [15:0]      r_to_cnt;
  logic [15:0]      w_to_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_stall;

  logic [5:0] w_opcode;
  logic       w_rs_used;
  logic       w_rt_used;
  logic       w_hazard;
  logic       w_to_expire;
  logic       w_hold;
  logic       unused_ins;

  assign w_opcode  = id_ins[31:26];
  assign w_rs_used = !(w_opcode inside {6'b000010, 6'b000011, 6'b001111});
  assign w_rt_used = w_opcode inside {6'b000000, 6'b000100, 6'b000101,
                                      6'b101011, 6'b101000};
  assign unused_ins = ^id_ins[15:0];

  assign w_hazard = ex_mem_read && (ex_write_reg != 5'd0) &&
                    ((w_rs_used && (ex_write_reg == id_ins[25:21])) ||
                     (w_rt_used && (ex_write_reg == id_ins[20:16])));

  // A forced release on timeout behaves exactly like mem_ready arriving.
  assign w_to_expire = (r_state == MWAIT) && !mem_ready && (r_to_cnt == c_to_last);
  assign w_hold      = (r_state == MWAIT) ? (!mem_ready && !w_to_expire)
                                          : (mem_req && !mem_ready);

  // On release, MWAIT resumes whatever it interrupted, tracked by the frozen count.
  assign w_eff_state = (r_state == MWAIT) ? ((r_ls_cnt != 2'd0) ? LSTALL : RUN)
                                          : r_state;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    w_state_nxt   = r_state;
    w_ls_cnt_nxt  = r_ls_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout_nxt = r_timeout;

    if (w_hold) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      w_state_nxt   = MWAIT;
      w_to_cnt_nxt  = (r_state == MWAIT) ? (r_to_cnt + 16'd1) : 16'd0;
    end else begin
      w_to_cnt_nxt = 16'd0;
      if (w_to_expire) begin
        w_timeout_nxt = 1'b1;
      end
      if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_ls_cnt_nxt = 2'd0;
        w_state_nxt  = RUN;
      end else if (w_eff_state == LSTALL) begin
        // EX holds a bubble here, so the hazard is not re-evaluated.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_flush  = 1'b1;
        w_ls_cnt_nxt = (r_ls_cnt != 2'd0) ? (r_ls_cnt - 2'd1) : 2'd0;
        w_state_nxt  = (r_ls_cnt > 2'd1) ? LSTALL : RUN;
      end else if (w_hazard) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_flush  = 1'b1;
        w_ls_cnt_nxt = c_ls_init;
        w_state_nxt  = (c_ls_init != 2'd0) ? LSTALL : RUN;
      end else begin
        w_state_nxt  = RUN;
      end
    end

    if (!rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= RUN;
      r_ls_cnt  <= 2'd0;
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ls_cnt  <= w_ls_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      if (!pc_en && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : directed-vector scoreboard bench for pipeline_hazard_ctrl
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_bubble}
  localparam logic [5:0] O_RUN = 6'b110010;
  localparam logic [5:0] O_LDU = 6'b000110;
  localparam logic [5:0] O_MW  = 6'b000001;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_RST = 6'b001101;

  localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
  localparam logic [31:0] ADD_3_0_2 = 32'h0002_1820;
  localparam logic [31:0] LUI_1     = 32'h3C01_1234;
  localparam logic [31:0] J_RS1     = 32'h0820_0000;
  localparam logic [31:0] ADDI_2_3  = 32'h2062_0004;
  localparam logic [31:0] SW_5_4    = 32'hAC85_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      id_ins = '0;
  logic             ex_mem_read = 1'b0;
  logic [4:0]       ex_write_reg = '0;
  logic             ex_branch_taken = 1'b0;
  logic             mem_req = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic             ex_mem_en, mem_wb_bubble, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       state;
  logic [24:0]      act;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(2),
    .MEM_TIMEOUT(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_ins(id_ins), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .state(state)
  );

  assign act = {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en,
                mem_wb_bubble, mem_timeout, state, stall_cycles};

  string       name_q[$];
  logic [24:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  // Inputs change 1ns after the rising edge; expectation for that cycle is queued.
  task automatic cyc(input string nm, input bit chk, input logic r,
                     input logic [31:0] ins, input logic mr, input logic [4:0] wr,
                     input logic br, input logic rq, input logic rdy,
                     input logic [5:0] ctl, input logic [1:0] st,
                     input logic mt, input int sc);
    logic [CNT_W-1:0] scv;
    @(posedge clk);
    #1;
    rst             = r;
    id_ins          = ins;
    ex_mem_read     = mr;
    ex_write_reg    = wr;
    ex_branch_taken = br;
    mem_req         = rq;
    mem_ready       = rdy;
    scv             = sc[CNT_W-1:0];
    if (chk) begin
      name_q.push_back(nm);
      exp_q.push_back({ctl, mt, st, scv});
    end
  endtask

  initial begin : monitor
    string       nm;
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got ctl=%b mt=%b st=%0d sc=%0d, want ctl=%b mt=%b st=%0d sc=%0d",
                   nm, act[24:19], act[18], act[17:16], act[15:0],
                   e[24:19], e[18], e[17:16], e[15:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    //  name        chk rst ins        mr wr  br rq rdy ctl    st mt sc
    cyc("rst0",     0, 0, '0,        0, 0,  0, 0, 0, O_RST, 0, 0, 0);
    cyc("rst1",     1, 0, '0,        0, 0,  0, 0, 0, O_RST, 0, 0, 0);
    cyc("idle_add", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 0);
    // load-use on rs
    cyc("lu_det",   1, 1, ADD_3_1_2, 1, 1,  0, 0, 0, O_LDU, 0, 0, 0);
    cyc("lu_hold",  1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_LDU, 1, 0, 1);
    cyc("lu_done",  1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 2);
    // hazard boundaries
    cyc("wr_zero",  1, 1, ADD_3_0_2, 1, 0,  0, 0, 0, O_RUN, 0, 0, 2);
    cyc("lui_rt",   1, 1, LUI_1,     1, 1,  0, 0, 0, O_RUN, 0, 0, 2);
    cyc("j_rsfld",  1, 1, J_RS1,     1, 1,  0, 0, 0, O_RUN, 0, 0, 2);
    cyc("addi_rt",  1, 1, ADDI_2_3,  1, 2,  0, 0, 0, O_RUN, 0, 0, 2);
    cyc("sw_det",   1, 1, SW_5_4,    1, 5,  0, 0, 0, O_LDU, 0, 0, 2);
    cyc("sw_hold",  1, 1, SW_5_4,    0, 0,  0, 0, 0, O_LDU, 1, 0, 3);
    cyc("sw_done",  1, 1, SW_5_4,    0, 0,  0, 0, 0, O_RUN, 0, 0, 4);
    // memory wait of 4 cycles
    cyc("mw_ent",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  0, 0, 4);
    cyc("mw_w1",    1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 5);
    cyc("mw_w2",    1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 6);
    cyc("mw_w3",    1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 7);
    cyc("mw_rel",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 1, O_RUN, 2, 0, 8);
    cyc("mw_after", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 8);
    // timeout: 8 waiting cycles then forced release
    cyc("to_ent",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  0, 0, 8);
    for (int k = 2; k <= 8; k++) begin
      cyc("to_wait", 1, 1, ADD_3_1_2, 0, 0, 0, 1, 0, O_MW,  2, 0, 7 + k);
    end
    cyc("to_rel",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_RUN, 2, 0, 16);
    cyc("to_stky1", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 1, 16);
    cyc("to_stky2", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 1, 16);
    cyc("to_rst",   1, 0, ADD_3_1_2, 0, 0,  0, 0, 0, O_RST, 0, 1, 16);
    cyc("to_clr",   1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 0);
    // reset in the middle of MWAIT
    cyc("rmw_ent",  1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  0, 0, 0);
    cyc("rmw_w",    1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 1);
    cyc("rmw_rst",  1, 0, ADD_3_1_2, 0, 0,  0, 1, 0, O_RST, 2, 0, 2);
    cyc("rmw_run",  1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 0);
    // load-use interrupted by memory wait, resumes one stall cycle
    cyc("lm_det",   1, 1, ADD_3_1_2, 1, 1,  0, 0, 0, O_LDU, 0, 0, 0);
    cyc("lm_mw1",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  1, 0, 1);
    cyc("lm_mw2",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 2);
    cyc("lm_mw3",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 0, O_MW,  2, 0, 3);
    cyc("lm_res",   1, 1, ADD_3_1_2, 0, 0,  0, 1, 1, O_LDU, 2, 0, 4);
    cyc("lm_run",   1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 5);
    // branch cancels LSTALL
    cyc("bl_det",   1, 1, ADD_3_1_2, 1, 1,  0, 0, 0, O_LDU, 0, 0, 5);
    cyc("bl_br",    1, 1, ADD_3_1_2, 0, 0,  1, 0, 0, O_BR,  1, 0, 6);
    cyc("bl_run",   1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 6);
    // branch beats load-use, memory wait beats branch
    cyc("br_haz",   1, 1, ADD_3_1_2, 1, 1,  1, 0, 0, O_BR,  0, 0, 6);
    cyc("br_after", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 6);
    cyc("mw_br",    1, 1, ADD_3_1_2, 0, 0,  1, 1, 0, O_MW,  0, 0, 6);
    cyc("mwbr_rel", 1, 1, ADD_3_1_2, 0, 0,  0, 1, 1, O_RUN, 2, 0, 7);
    cyc("mwbr_run", 1, 1, ADD_3_1_2, 0, 0,  0, 0, 0, O_RUN, 0, 0, 7);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
